// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline types: operand/data width, register index width,
// operand-stage FSM encoding and the decoded-instruction field bundle
// that travels from decode through the operand stage into execute.
package rv32_pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } op_state_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 rs1_read;
    logic                 rs2_read;
    logic                 rd_write;
    logic                 mem_read;
  } dec_fields_t;

endpackage

// File: rtl/rv32_bypass_mux.sv
// Per-operand priority forwarding mux for the operand stage (combinational).
// Ports: rs_i/rs_read_i select and qualify the operand; reg_value_i is the
// register-file read; ex_*, mem_*, wb_* are the bypass sources in priority
// order; value_o is the resolved operand; load_use_o / mem_pending_o flag
// the two ways this operand can force a bubble.
module rv32_bypass_mux
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic                 rs_read_i,
  input  logic [XLEN-1:0]      reg_value_i,
  input  logic                 ex_wr_i,        // execute slot valid and writes rd
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_is_load_i,
  input  logic [XLEN-1:0]      ex_result_i,
  input  logic                 mem_rd_write_i,
  input  logic [REG_IDX_W-1:0] mem_rd_i,
  input  logic                 mem_result_valid_i,
  input  logic [XLEN-1:0]      mem_result_i,
  input  logic                 wb_rd_write_i,
  input  logic                 wb_flush_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_value_i,
  output logic [XLEN-1:0]      value_o,
  output logic                 load_use_o,
  output logic                 mem_pending_o
);

  logic rs_nz;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign rs_nz   = (rs_i != '0);
  // ex_hit covers both ALU results and loads: a load in execute still owns
  // the register, so the memory stage must not be consulted behind it.
  assign ex_hit  = rs_nz && ex_wr_i && (ex_rd_i == rs_i);
  assign mem_hit = rs_nz && mem_rd_write_i && (mem_rd_i == rs_i);
  assign wb_hit  = rs_nz && wb_rd_write_i && !wb_flush_i && (wb_rd_i == rs_i);

  always_comb begin
    value_o = reg_value_i;
    if (!rs_nz) begin
      value_o = '0;
    end else if (ex_hit && !ex_is_load_i) begin
      value_o = ex_result_i;
    end else if (mem_hit) begin
      value_o = mem_result_i;
    end else if (wb_hit) begin
      value_o = wb_value_i;
    end
  end

  assign load_use_o    = rs_read_i && ex_hit && ex_is_load_i;
  assign mem_pending_o = rs_read_i && !ex_hit && mem_hit && !mem_result_valid_i;

endmodule

// File: rtl/rv32_operand_stage.sv
// RV32 register-read stage: captures decode fields (stage A), resolves
// operands from rv32_regs plus execute/memory/writeback bypass, inserts
// bubbles on load-use or pending-memory hazards and registers the result
// for execute. Decode to out_* is two edges when no hazard is present.
// Ports: clk/reset (sync, active-high); stall_in/flush_in pipeline control;
// stall_out back to decode and rv32_regs; dec_* decode slot; rs*_value_in
// register reads; ex/mem/wb bypass sources; out_* execute slot;
// stall_count saturating hazard-stall cycle counter.
module rv32_operand_stage
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic                   stall_out,
  input  logic                   dec_valid_in,
  input  logic [XLEN-1:0]        dec_pc_in,
  input  logic [REG_IDX_W-1:0]   dec_rs1_in,
  input  logic [REG_IDX_W-1:0]   dec_rs2_in,
  input  logic [REG_IDX_W-1:0]   dec_rd_in,
  input  logic                   dec_rs1_read_in,
  input  logic                   dec_rs2_read_in,
  input  logic                   dec_rd_write_in,
  input  logic                   dec_mem_read_in,
  input  logic [XLEN-1:0]        rs1_value_in,
  input  logic [XLEN-1:0]        rs2_value_in,
  input  logic [XLEN-1:0]        ex_result_in,
  input  logic [REG_IDX_W-1:0]   mem_rd_in,
  input  logic                   mem_rd_write_in,
  input  logic                   mem_result_valid_in,
  input  logic [XLEN-1:0]        mem_result_in,
  input  logic [REG_IDX_W-1:0]   wb_rd_in,
  input  logic                   wb_rd_write_in,
  input  logic                   wb_flush_in,
  input  logic [XLEN-1:0]        wb_value_in,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_rs1_value,
  output logic [XLEN-1:0]        out_rs2_value,
  output logic [REG_IDX_W-1:0]   out_rd,
  output logic                   out_rd_write,
  output logic                   out_mem_read,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Stage A: decoded instruction waiting for its register reads.
  logic             a_valid_q, a_valid_d;
  dec_fields_t      a_q, a_d;

  // Execute slot.
  logic             out_valid_q, out_valid_d;
  dec_fields_t      out_q, out_d;
  logic [XLEN-1:0]  out_rs1_q, out_rs1_d;
  logic [XLEN-1:0]  out_rs2_q, out_rs2_d;

  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  op_state_t        state_q, state_d;

  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             rs1_load_use, rs2_load_use;
  logic             rs1_mem_pend, rs2_mem_pend;
  logic             ex_wr;
  logic             hazard;
  dec_fields_t      dec_fields;

  assign ex_wr = out_valid_q && out_q.rd_write;

  rv32_bypass_mux #(.XLEN(XLEN)) u_byp_rs1 (
    .rs_i               (a_q.rs1),
    .rs_read_i          (a_q.rs1_read),
    .reg_value_i        (rs1_value_in),
    .ex_wr_i            (ex_wr),
    .ex_rd_i            (out_q.rd),
    .ex_is_load_i       (out_q.mem_read),
    .ex_result_i        (ex_result_in),
    .mem_rd_write_i     (mem_rd_write_in),
    .mem_rd_i           (mem_rd_in),
    .mem_result_valid_i (mem_result_valid_in),
    .mem_result_i       (mem_result_in),
    .wb_rd_write_i      (wb_rd_write_in),
    .wb_flush_i         (wb_flush_in),
    .wb_rd_i            (wb_rd_in),
    .wb_value_i         (wb_value_in),
    .value_o            (rs1_fwd),
    .load_use_o         (rs1_load_use),
    .mem_pending_o      (rs1_mem_pend)
  );

  rv32_bypass_mux #(.XLEN(XLEN)) u_byp_rs2 (
    .rs_i               (a_q.rs2),
    .rs_read_i          (a_q.rs2_read),
    .reg_value_i        (rs2_value_in),
    .ex_wr_i            (ex_wr),
    .ex_rd_i            (out_q.rd),
    .ex_is_load_i       (out_q.mem_read),
    .ex_result_i        (ex_result_in),
    .mem_rd_write_i     (mem_rd_write_in),
    .mem_rd_i           (mem_rd_in),
    .mem_result_valid_i (mem_result_valid_in),
    .mem_result_i       (mem_result_in),
    .wb_rd_write_i      (wb_rd_write_in),
    .wb_flush_i         (wb_flush_in),
    .wb_rd_i            (wb_rd_in),
    .wb_value_i         (wb_value_in),
    .value_o            (rs2_fwd),
    .load_use_o         (rs2_load_use),
    .mem_pending_o      (rs2_mem_pend)
  );

  // Reset gating keeps stall_out equal to stall_in while reset is held.
  assign hazard = !reset && a_valid_q &&
                  (rs1_load_use || rs2_load_use || rs1_mem_pend || rs2_mem_pend);
  assign stall_out = stall_in || hazard;

  assign dec_fields = '{pc:       dec_pc_in,
                        rs1:      dec_rs1_in,
                        rs2:      dec_rs2_in,
                        rd:       dec_rd_in,
                        rs1_read: dec_rs1_read_in,
                        rs2_read: dec_rs2_read_in,
                        rd_write: dec_rd_write_in,
                        mem_read: dec_mem_read_in};

  // Datapath next state: flush beats stall, stall beats hazard.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    cnt_d       = cnt_q;
    if (flush_in) begin
      a_valid_d   = 1'b0;
      out_valid_d = 1'b0;
    end else if (!stall_in) begin
      if (hazard) begin
        out_valid_d = 1'b0;
        out_d       = '0;
        out_rs1_d   = '0;
        out_rs2_d   = '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + STALL_CNT_W'(1);
        end
      end else begin
        out_valid_d = a_valid_q;
        out_d       = a_valid_q ? a_q : '0;
        out_rs1_d   = a_valid_q ? rs1_fwd : '0;
        out_rs2_d   = a_valid_q ? rs2_fwd : '0;
        a_valid_d   = dec_valid_in;
        a_d         = dec_fields;
      end
    end
  end

  // FSM next state: tracks whether stage A is being held for a hazard.
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = RUN;
    end else if (!stall_in) begin
      state_d = hazard ? LOAD_WAIT : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      cnt_q       <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_rs1_value = out_rs1_q;
  assign out_rs2_value = out_rs2_q;
  assign out_rd        = out_q.rd;
  assign out_rd_write  = out_q.rd_write;
  assign out_mem_read  = out_q.mem_read;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_rv32_operand_stage.sv
// Self-checking bench for rv32_operand_stage: directed pipeline scenarios
// followed by randomized traffic against a behavioural stage model.
module tb_rv32_operand_stage;

  localparam int XLEN = 32;
  localparam int CW   = 4;   // narrow counter so saturation is reachable

  logic            clk = 1'b0;
  logic            reset, stall_in, flush_in;
  logic            dec_valid_in;
  logic [31:0]     dec_pc_in;
  logic [4:0]      dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic            dec_rs1_read_in, dec_rs2_read_in, dec_rd_write_in, dec_mem_read_in;
  logic [31:0]     rs1_value_in, rs2_value_in, ex_result_in;
  logic [4:0]      mem_rd_in, wb_rd_in;
  logic            mem_rd_write_in, mem_result_valid_in;
  logic [31:0]     mem_result_in, wb_value_in;
  logic            wb_rd_write_in, wb_flush_in;
  logic            stall_out, out_valid, out_rd_write, out_mem_read;
  logic [31:0]     out_pc, out_rs1_value, out_rs2_value;
  logic [4:0]      out_rd;
  logic [CW-1:0]   stall_count;

  always #5 clk = ~clk;

  rv32_operand_stage #(.XLEN(XLEN), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .stall_out(stall_out), .dec_valid_in(dec_valid_in), .dec_pc_in(dec_pc_in),
    .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
    .dec_rs1_read_in(dec_rs1_read_in), .dec_rs2_read_in(dec_rs2_read_in),
    .dec_rd_write_in(dec_rd_write_in), .dec_mem_read_in(dec_mem_read_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .ex_result_in(ex_result_in), .mem_rd_in(mem_rd_in),
    .mem_rd_write_in(mem_rd_write_in), .mem_result_valid_in(mem_result_valid_in),
    .mem_result_in(mem_result_in), .wb_rd_in(wb_rd_in),
    .wb_rd_write_in(wb_rd_write_in), .wb_flush_in(wb_flush_in),
    .wb_value_in(wb_value_in), .out_valid(out_valid), .out_pc(out_pc),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
    .out_rd(out_rd), .out_rd_write(out_rd_write), .out_mem_read(out_mem_read),
    .stall_count(stall_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        r1, r2, w, mr;
  } instr_t;

  instr_t        m_a, m_out;
  logic [31:0]   m_o1, m_o2;
  logic [CW-1:0] m_cnt;

  // Value an instruction in stage A should see for register rs this cycle.
  function automatic logic [31:0] m_resolve(input logic [4:0] rs, input logic [31:0] regv);
    if (rs == 5'd0) return 32'd0;
    if (m_out.v && m_out.w && m_out.rd == rs && !m_out.mr) return ex_result_in;
    if (mem_rd_write_in && mem_rd_in == rs) return mem_result_in;
    if (wb_rd_write_in && !wb_flush_in && wb_rd_in == rs) return wb_value_in;
    return regv;
  endfunction

  // Does reading rs right now have to wait?
  function automatic logic m_blocks(input logic [4:0] rs, input logic used);
    if (!used || rs == 5'd0) return 1'b0;
    if (m_out.v && m_out.w && m_out.rd == rs) return m_out.mr;
    return mem_rd_write_in && mem_rd_in == rs && !mem_result_valid_in;
  endfunction

  function automatic logic m_hazard();
    if (reset || !m_a.v) return 1'b0;
    return m_blocks(m_a.rs1, m_a.r1) || m_blocks(m_a.rs2, m_a.r2);
  endfunction

  // One clock cycle: check stall_out, advance model, check registered outputs.
  task automatic tick();
    logic        hz;
    logic [31:0] e1, e2;
    instr_t      d;
    #1;
    hz = m_hazard();
    chk("stall_out", 32'(stall_out), 32'(stall_in | hz));
    e1 = m_resolve(m_a.rs1, rs1_value_in);
    e2 = m_resolve(m_a.rs2, rs2_value_in);
    d  = '{v: dec_valid_in, pc: dec_pc_in, rs1: dec_rs1_in, rs2: dec_rs2_in, rd: dec_rd_in,
           r1: dec_rs1_read_in, r2: dec_rs2_read_in, w: dec_rd_write_in, mr: dec_mem_read_in};
    if (reset) begin
      m_a = '0; m_out = '0; m_o1 = '0; m_o2 = '0; m_cnt = '0;
    end else if (flush_in) begin
      m_a.v = 1'b0; m_out.v = 1'b0;
    end else if (!stall_in) begin
      if (hz) begin
        m_out.v = 1'b0;
        if (m_cnt != '1) m_cnt++;
      end else begin
        m_out = m_a; m_o1 = e1; m_o2 = e2; m_a = d;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_out.v));
    if (m_out.v) begin
      chk("out_pc", out_pc, m_out.pc);
      chk("out_rs1_value", out_rs1_value, m_o1);
      chk("out_rs2_value", out_rs2_value, m_o2);
      chk("out_rd", 32'(out_rd), 32'(m_out.rd));
      chk("out_rd_write", 32'(out_rd_write), 32'(m_out.w));
      chk("out_mem_read", 32'(out_mem_read), 32'(m_out.mr));
    end
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
  endtask

  // ---------------- stimulus helpers ----------------
  logic [31:0] pc_next = 32'h1000;

  task automatic idle();
    reset = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    dec_valid_in = 1'b0; dec_pc_in = '0; dec_rs1_in = '0; dec_rs2_in = '0; dec_rd_in = '0;
    dec_rs1_read_in = 1'b0; dec_rs2_read_in = 1'b0; dec_rd_write_in = 1'b0; dec_mem_read_in = 1'b0;
    rs1_value_in = '0; rs2_value_in = '0; ex_result_in = '0;
    mem_rd_in = '0; mem_rd_write_in = 1'b0; mem_result_valid_in = 1'b1; mem_result_in = '0;
    wb_rd_in = '0; wb_rd_write_in = 1'b0; wb_flush_in = 1'b0; wb_value_in = '0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic r1, input logic r2, input logic w, input logic mr);
    dec_valid_in = 1'b1; dec_pc_in = pc_next; pc_next += 32'd4;
    dec_rs1_in = rs1; dec_rs2_in = rs2; dec_rd_in = rd;
    dec_rs1_read_in = r1; dec_rs2_read_in = r2; dec_rd_write_in = w; dec_mem_read_in = mr;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); idle();
  endtask

  task automatic mem_pend(input logic [4:0] rd);
    mem_rd_in = rd; mem_rd_write_in = 1'b1; mem_result_valid_in = 1'b0;
    mem_result_in = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc11;
    m_a = '0; m_out = '0; m_o1 = '0; m_o2 = '0; m_cnt = '0;
    idle();
    reset = 1'b1; stall_in = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);

    // ADD x5 <- x1+x2, then ADD x6 <- x5+x5 through the execute bypass
    do_reset();
    dec(5'd1, 5'd2, 5'd5, 1, 1, 1, 0); tick();
    idle(); rs1_value_in = 32'd1; rs2_value_in = 32'd2; dec(5'd5, 5'd5, 5'd6, 1, 1, 1, 0); tick();
    chk("add1_rs1", out_rs1_value, 32'd1);
    idle(); ex_result_in = 32'd3; #1 chk("exfwd_no_stall", 32'(stall_out), 32'd0); tick();
    chk("exfwd_rs1", out_rs1_value, 32'd3);
    chk("exfwd_rs2", out_rs2_value, 32'd3);
    chk("exfwd_rd", 32'(out_rd), 32'd6);

    // LW x7 then ADD x8 <- x7: one bubble, then memory-forwarded value
    do_reset();
    dec(5'd1, 5'd0, 5'd7, 1, 0, 1, 1); tick();
    idle(); dec(5'd7, 5'd0, 5'd8, 1, 0, 1, 0); tick();
    idle(); #1 chk("lu_stall", 32'(stall_out), 32'd1); tick();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_cnt", 32'(stall_count), 32'd1);
    idle(); mem_rd_in = 5'd7; mem_rd_write_in = 1'b1; mem_result_in = 32'hDEADBEEF;
    #1 chk("lu_release", 32'(stall_out), 32'd0); tick();
    chk("lu_issue", 32'(out_valid), 32'd1);
    chk("lu_value", out_rs1_value, 32'hDEADBEEF);

    // Writeback bypass, then the same with the writeback flushed
    do_reset();
    dec(5'd9, 5'd0, 5'd3, 1, 0, 1, 0); tick();
    idle(); wb_rd_in = 5'd9; wb_rd_write_in = 1'b1; wb_value_in = 32'h55; rs1_value_in = 32'h11;
    dec(5'd9, 5'd0, 5'd4, 1, 0, 1, 0); tick();
    chk("wb_fwd", out_rs1_value, 32'h55);
    idle(); wb_rd_in = 5'd9; wb_rd_write_in = 1'b1; wb_flush_in = 1'b1; wb_value_in = 32'h55;
    rs1_value_in = 32'h11; tick();
    chk("wb_flushed", out_rs1_value, 32'h11);

    // x0 is never forwarded nor a hazard source
    do_reset();
    dec(5'd1, 5'd1, 5'd0, 1, 1, 1, 1); tick();
    idle(); dec(5'd0, 5'd0, 5'd4, 1, 1, 1, 0); tick();
    idle(); ex_result_in = '1; mem_rd_in = 5'd0; mem_rd_write_in = 1'b1; mem_result_valid_in = 1'b0;
    mem_result_in = '1; wb_rd_in = 5'd0; wb_rd_write_in = 1'b1; wb_value_in = '1;
    rs1_value_in = '1; rs2_value_in = '1;
    #1 chk("x0_no_hazard", 32'(stall_out), 32'd0); tick();
    chk("x0_valid", 32'(out_valid), 32'd1);
    chk("x0_rs1", out_rs1_value, 32'd0);
    chk("x0_rs2", out_rs2_value, 32'd0);

    // Load to x10 outstanding for three cycles
    do_reset();
    dec(5'd10, 5'd0, 5'd5, 1, 0, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); mem_pend(5'd10);
      #1 chk("mp_stall", 32'(stall_out), 32'd1); tick();
      chk("mp_bubble", 32'(out_valid), 32'd0);
    end
    idle(); mem_rd_in = 5'd10; mem_rd_write_in = 1'b1; mem_result_in = 32'h1234_5678; tick();
    chk("mp_issue", 32'(out_valid), 32'd1);
    chk("mp_value", out_rs1_value, 32'h1234_5678);
    chk("mp_cnt", 32'(stall_count), 32'd3);

    // Flush in the middle of a pending-memory stall
    do_reset();
    dec(5'd10, 5'd0, 5'd5, 1, 0, 1, 0); tick();
    idle(); mem_pend(5'd10); tick();
    idle(); mem_pend(5'd10); flush_in = 1'b1; tick();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_cnt", 32'(stall_count), 32'd1);
    idle(); mem_pend(5'd10); #1 chk("fl_unstall", 32'(stall_out), 32'd0); tick();

    // Counter saturation
    do_reset();
    dec(5'd10, 5'd0, 5'd5, 1, 0, 1, 0); tick();
    for (int i = 0; i < 18; i++) begin idle(); mem_pend(5'd10); tick(); end
    chk("cnt_sat", 32'(stall_count), 32'(2**CW - 1));

    // Global stall freezes everything, then reset mid-hazard
    do_reset();
    pc11 = pc_next;
    dec(5'd1, 5'd2, 5'd11, 1, 1, 1, 0); tick();
    idle(); rs1_value_in = 32'h111; rs2_value_in = 32'h222; dec(5'd12, 5'd0, 5'd13, 1, 0, 1, 0); tick();
    for (int i = 0; i < 4; i++) begin
      idle(); stall_in = 1'b1; mem_pend(5'd12);
      dec(5'($urandom_range(1, 31)), 5'd3, 5'd4, 1, 1, 1, 0);
      rs1_value_in = $urandom; ex_result_in = $urandom;
      tick();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_pc", out_pc, pc11);
      chk("st_rs1", out_rs1_value, 32'h111);
      chk("st_rs2", out_rs2_value, 32'h222);
      chk("st_cnt", 32'(stall_count), 32'd0);
    end
    idle(); mem_pend(5'd12); tick();
    chk("st_hz_cnt", 32'(stall_count), 32'd1);
    idle(); mem_pend(5'd12); reset = 1'b1; tick();
    chk("rst_hz_valid", 32'(out_valid), 32'd0);
    chk("rst_hz_cnt", 32'(stall_count), 32'd0);
    idle(); mem_pend(5'd12); #1 chk("rst_hz_unstall", 32'(stall_out), 32'd0); tick();

    // Randomized traffic over a small register window to provoke collisions
    do_reset();
    repeat (3000) begin
      reset               = ($urandom_range(0, 199) == 0);
      stall_in            = ($urandom_range(0, 9) == 0);
      flush_in            = ($urandom_range(0, 19) == 0);
      dec_valid_in        = 1'($urandom);
      dec_pc_in           = $urandom;
      dec_rs1_in          = 5'($urandom_range(0, 3));
      dec_rs2_in          = 5'($urandom_range(0, 3));
      dec_rd_in           = 5'($urandom_range(0, 3));
      dec_rs1_read_in     = 1'($urandom);
      dec_rs2_read_in     = 1'($urandom);
      dec_rd_write_in     = 1'($urandom);
      dec_mem_read_in     = ($urandom_range(0, 2) == 0);
      rs1_value_in        = $urandom;
      rs2_value_in        = $urandom;
      ex_result_in        = $urandom;
      mem_rd_in           = 5'($urandom_range(0, 3));
      mem_rd_write_in     = 1'($urandom);
      mem_result_valid_in = ($urandom_range(0, 2) != 0);
      mem_result_in       = $urandom;
      wb_rd_in            = 5'($urandom_range(0, 3));
      wb_rd_write_in      = 1'($urandom);
      wb_flush_in         = ($urandom_range(0, 4) == 0);
      wb_value_in         = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv32_operand_stage.md
Name: rv32_operand_stage

Overview:
- Register-read stage between decode and execute in the RV32 pipeline.
- Captures decoded instruction fields on the same edge that rv32_regs latches rs1/rs2. One cycle later it combines the rv32_regs read values with bypass data from execute, memory and writeback.
- Detects load-use hazards, inserts bubbles, and registers the resolved operands for the execute stage.
- Keeps a saturating count of hazard-stall cycles for debug.

Parameters:
- XLEN, 32, data/operand width.
- STALL_CNT_W, 32, width of the hazard-stall counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- stall_in  in  1  global freeze from downstream; holds all state
- flush_in  in  1  branch/trap flush; kills stage A and output bubble
- stall_out  out  1  stall to decode and rv32_regs.stall_in; equals stall_in OR hazard
- dec_valid_in  in  1  decode slot valid
- dec_pc_in  in  XLEN  instruction PC
- dec_rs1_in, dec_rs2_in, dec_rd_in  in  5 each  register indices
- dec_rs1_read_in, dec_rs2_read_in  in  1 each  operand actually used
- dec_rd_write_in  in  1  instruction writes rd
- dec_mem_read_in  in  1  instruction is a load
- rs1_value_in, rs2_value_in  in  XLEN each  rv32_regs read data, aligned with stage A
- ex_result_in  in  XLEN  execute ALU result for the instruction currently in out_*
- mem_rd_in  in  5  destination of the memory-stage instruction
- mem_rd_write_in  in  1  memory-stage instruction writes rd
- mem_result_valid_in  in  1  mem_result_in is final (0 while a load is outstanding)
- mem_result_in  in  XLEN  memory-stage result
- wb_rd_in  in  5  writeback destination
- wb_rd_write_in  in  1  writeback writes rd
- wb_flush_in  in  1  writeback flush (same signal driving rv32_regs)
- wb_value_in  in  XLEN  writeback value
- out_valid  out  1  execute slot valid
- out_pc  out  XLEN  PC for execute
- out_rs1_value, out_rs2_value  out  XLEN each  resolved operands
- out_rd  out  5  destination register
- out_rd_write  out  1  writes rd
- out_mem_read  out  1  instruction is a load
- stall_count  out  STALL_CNT_W  hazard-stall cycles, saturating

Behaviour:

Reset:
- All out_* = 0.
- Stage A valid = 0, state = RUN, stall_count = 0.
- stall_out follows stall_in only.

Stage A capture:
- When !stall_out: register the dec_* fields into stage A.
- Latency decode→out_* is 2 edges with no hazards.

Operand resolve (combinational in stage A), per source operand, priority high to low:
- Index 0 → 0, never forwarded.
- Forward from execute: out_valid && out_rd_write && out_rd==rs && !out_mem_read → ex_result_in.
- Forward from memory: mem_rd_write_in && mem_rd_in==rs → mem_result_in.
- Forward from writeback: wb_rd_write_in && !wb_flush_in && wb_rd_in==rs → wb_value_in. The rv32_regs write lands at the same edge, so this bypass is mandatory.
- Otherwise use rs*_value_in.

Hazard:
- Applies only while stage A is valid and the operand is read (rs*_read).
- load_use: out_valid && out_mem_read && out_rd_write && out_rd!=0 && out_rd matches a read operand.
- mem_pending: mem_rd_write_in && mem_rd_in!=0 && !mem_result_valid_in && mem_rd_in matches a read operand. This applies only where no higher-priority source (execute) matches.
- hazard = load_use || mem_pending.

FSM states:
- RUN: no hazard.
- LOAD_WAIT: hazard asserted.
- Transitions: RUN→LOAD_WAIT when hazard && !stall_in && !flush_in. LOAD_WAIT→RUN when hazard clears or flush_in.
- State holds while stall_in.

Output register update, in priority order:
- reset.
- flush_in: out_valid=0, stage A valid=0.
- stall_in: hold everything.
- hazard: out_valid=0 (bubble), stage A held. Other out_* fields are don't-care but are driven to 0.
- Otherwise: load out_* from stage A with the resolved operands.

Further rules:
- flush_in during hazard clears stage A; stall_out deasserts the following cycle.
- stall_count increments by 1 on each cycle with hazard && !stall_in && !flush_in. It saturates at all-ones and clears only on reset.
- Invalid stage A never raises hazard and loads out_valid=0.

Decomposition:
- Shared package rv32_pipe_pkg holds:
  - XLEN and REG_IDX_W=5 constants.
  - Enum op_state_t {RUN, LOAD_WAIT}.
  - Struct dec_fields_t (pc, rs1, rs2, rd, read/write/mem flags), reused by decode and execute.
- One natural sub-module, rv32_bypass_mux: a per-operand priority forward mux.
  - Instantiated twice, for rs1 and rs2.
  - Combinational; also outputs per-operand hazard-match bits.

Test Plan:
- Back-to-back ADD x5←1+2 then ADD x6←x5+x5 → second instruction sees out_rs1_value=out_rs2_value=3 via execute bypass, no stall.
- LW x7 followed directly by ADD x8←x7 → exactly one bubble (out_valid=0 one cycle), stall_out high one cycle, stall_count=1. Then ADD issues with the mem-forwarded load value 0xDEADBEEF.
- Writeback of x9=0x55 on the same cycle stage A reads x9 → out_rs1_value=0x55. Repeat with wb_flush_in=1 → value from rs1_value_in.
- Instruction reading x0 while execute, memory and writeback all write rd=0 with value 0xFFFFFFFF → out_rs1_value=0, no hazard.
- mem_result_valid_in held low 3 cycles for a load to x10, consumer in stage A → 3 bubbles, stall_count=3, operand correct on the 4th cycle. flush_in in cycle 2 → out_valid=0, stall_out low next cycle.
- stall_in high 4 cycles mid-stream → out_* frozen, stall_count unchanged. Synchronous reset mid-hazard → out_valid=0, state RUN, stall_count=0 after the edge.
